// File: rtl/traceback_stream.sv
// Streaming traceback engine: walks the alignment matrix backwards from a
// start cell, reading one direction packet per step from matrix memory, and
// emits one aligned column (query symbol, database symbol) per beat, framed
// by marker beats at the start and end of each alignment.
module traceback_stream #(
    parameter int SEQ_LENGTH   = 32,
    parameter int SEQ_LENGTH_W = $clog2(SEQ_LENGTH),
    parameter int LETTER_WIDTH = 2,
    parameter int LEN_W        = $clog2(2*SEQ_LENGTH+1)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic                               abort,
    input  logic [SEQ_LENGTH_W-1:0]            max_row,
    input  logic [SEQ_LENGTH_W-1:0]            max_col,
    output logic                               busy,
    output logic                               done,
    output logic                               err,
    output logic                               mem_rd_en,
    output logic [SEQ_LENGTH_W-1:0]            mem_rd_row,
    output logic [SEQ_LENGTH_W-1:0]            mem_rd_col,
    input  logic                               mem_rd_valid,
    input  logic [2:0]                         mem_rd_data,
    input  logic [SEQ_LENGTH*LETTER_WIDTH-1:0] query_seq,
    input  logic [SEQ_LENGTH*LETTER_WIDTH-1:0] database_seq,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [LETTER_WIDTH:0]              query_out,
    output logic [LETTER_WIDTH:0]              database_out,
    output logic                               out_last,
    output logic [LEN_W-1:0]                   align_len
);

    // Symbol encodings: letter = {0, code}, gap = {1, zeros}, marker = all ones
    localparam logic [LETTER_WIDTH:0] MARKER  = '1;
    localparam logic [LETTER_WIDTH:0] GAP     = {1'b1, {LETTER_WIDTH{1'b0}}};
    localparam logic [LEN_W-1:0]      LEN_MAX = LEN_W'(2*SEQ_LENGTH);

    typedef enum logic [2:0] {
        IDLE,
        START_MARK,
        FETCH,
        WAIT,
        EMIT,
        END_MARK
    } state_t;

    state_t                    state_q, state_d;
    logic [SEQ_LENGTH_W-1:0]   row_q, row_d;
    logic [SEQ_LENGTH_W-1:0]   col_q, col_d;
    logic [LEN_W-1:0]          len_q, len_d;
    logic                      err_q, err_d;
    logic                      done_q, done_d;
    logic [1:0]                dir_q, dir_d;

    logic [LETTER_WIDTH-1:0]   query_arr    [SEQ_LENGTH];
    logic [LETTER_WIDTH-1:0]   database_arr [SEQ_LENGTH];
    logic [LEN_W-1:0]          len_inc;
    logic                      dec_row;
    logic                      dec_col;
    logic                      underflow;
    logic                      rd_is_stop;

    // Unpack the flat letter vectors so a row/col index selects a letter directly
    for (genvar i = 0; i < SEQ_LENGTH; i++) begin : g_unpack
        assign query_arr[i]    = query_seq[i*LETTER_WIDTH +: LETTER_WIDTH];
        assign database_arr[i] = database_seq[i*LETTER_WIDTH +: LETTER_WIDTH];
    end

    // Direction bit 1 moves up (TOP/DIAG), bit 0 moves left (LEFT/DIAG)
    assign dec_row    = dir_q[1];
    assign dec_col    = dir_q[0];
    assign underflow  = (dec_row && (row_q == '0)) || (dec_col && (col_q == '0));
    assign len_inc    = (len_q == LEN_MAX) ? len_q : len_q + 1'b1;
    assign rd_is_stop = mem_rd_data[2] || (mem_rd_data[1:0] == 2'b00);

    // Next-state and datapath updates; abort overrides every other transition
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        len_d   = len_q;
        err_d   = err_q;
        done_d  = 1'b0;
        dir_d   = dir_q;
        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = START_MARK;
                        row_d   = max_row;
                        col_d   = max_col;
                        len_d   = '0;
                        err_d   = 1'b0;
                    end
                end
                START_MARK: begin
                    if (out_ready) begin
                        state_d = FETCH;
                    end
                end
                FETCH: begin
                    state_d = WAIT;
                end
                WAIT: begin
                    if (mem_rd_valid) begin
                        dir_d   = mem_rd_data[1:0];
                        state_d = rd_is_stop ? END_MARK : EMIT;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        len_d = len_inc;
                        if (underflow) begin
                            err_d   = 1'b1;
                            state_d = END_MARK;
                        end else begin
                            if (dec_row) begin
                                row_d = row_q - 1'b1;
                            end
                            if (dec_col) begin
                                col_d = col_q - 1'b1;
                            end
                            if (len_inc == LEN_MAX) begin
                                err_d   = 1'b1;
                                state_d = END_MARK;
                            end else begin
                                state_d = FETCH;
                            end
                        end
                    end
                end
                END_MARK: begin
                    if (out_ready) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers, cleared asynchronously by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            dir_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            len_q   <= len_d;
            err_q   <= err_d;
            done_q  <= done_d;
            dir_q   <= dir_d;
        end
    end

    // Stream outputs decoded from the current state and captured direction
    always_comb begin
        out_valid    = 1'b0;
        out_last     = 1'b0;
        query_out    = '0;
        database_out = '0;
        case (state_q)
            START_MARK: begin
                out_valid    = 1'b1;
                query_out    = MARKER;
                database_out = MARKER;
            end
            EMIT: begin
                out_valid    = 1'b1;
                query_out    = dec_col ? {1'b0, query_arr[col_q]} : GAP;
                database_out = dec_row ? {1'b0, database_arr[row_q]} : GAP;
            end
            END_MARK: begin
                out_valid    = 1'b1;
                out_last     = 1'b1;
                query_out    = MARKER;
                database_out = MARKER;
            end
            default: begin
                out_valid = 1'b0;
            end
        endcase
    end

    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign err        = err_q;
    assign align_len  = len_q;
    assign mem_rd_en  = (state_q == FETCH);
    assign mem_rd_row = row_q;
    assign mem_rd_col = col_q;

endmodule

// File: tb/tb_traceback_stream.sv
// Directed testbench for traceback_stream: a scoreboard queue holds the
// expected output beats, pushed when a traceback is launched and popped by a
// monitor whenever the DUT completes an output handshake.
module tb_traceback_stream;

    localparam int SL   = 32;
    localparam int SW   = 5;
    localparam int LW   = 2;
    localparam int LENW = 7;

    localparam logic [2:0] MARK = 3'b111;
    localparam logic [2:0] GAP  = 3'b100;
    localparam logic [2:0] DIAG = 3'b011;
    localparam logic [2:0] LEFT = 3'b001;
    localparam logic [2:0] TOP  = 3'b010;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic               abort;
    logic [SW-1:0]      max_row;
    logic [SW-1:0]      max_col;
    logic               busy;
    logic               done;
    logic               err;
    logic               mem_rd_en;
    logic [SW-1:0]      mem_rd_row;
    logic [SW-1:0]      mem_rd_col;
    logic               mem_rd_valid;
    logic [2:0]         mem_rd_data;
    logic [SL*LW-1:0]   query_seq;
    logic [SL*LW-1:0]   database_seq;
    logic               out_valid;
    logic               out_ready;
    logic [LW:0]        query_out;
    logic [LW:0]        database_out;
    logic               out_last;
    logic [LENW-1:0]    align_len;

    int pass_count  = 0;
    int check_count = 0;
    int done_count  = 0;
    int rd_en_count = 0;
    int done_base;
    int rd_base;

    logic [6:0] exp_q [$];

    traceback_stream #(
        .SEQ_LENGTH   (SL),
        .SEQ_LENGTH_W (SW),
        .LETTER_WIDTH (LW),
        .LEN_W        (LENW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .max_row      (max_row),
        .max_col      (max_col),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .mem_rd_en    (mem_rd_en),
        .mem_rd_row   (mem_rd_row),
        .mem_rd_col   (mem_rd_col),
        .mem_rd_valid (mem_rd_valid),
        .mem_rd_data  (mem_rd_data),
        .query_seq    (query_seq),
        .database_seq (database_seq),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .query_out    (query_out),
        .database_out (database_out),
        .out_last     (out_last),
        .align_len    (align_len)
    );

    // Free-running 10-unit clock
    always #5 clk = ~clk;

    // Global time limit so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [2:0] q_sym(input int i);
        return {1'b0, query_seq[i*LW +: LW]};
    endfunction

    function automatic logic [2:0] d_sym(input int i);
        return {1'b0, database_seq[i*LW +: LW]};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [SW-1:0] row, input logic [SW-1:0] col);
        max_row = row;
        max_col = col;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        max_row = SW'($urandom);
        max_col = SW'($urandom);
    endtask

    task automatic wait_rd_en(input int er, input int ec);
        int n = 0;
        while (!mem_rd_en && n < 30) begin
            tick();
            n++;
        end
        checkOutput("rd_en_seen", 32'(mem_rd_en), 1);
        checkOutput("rd_row", 32'(mem_rd_row), er);
        checkOutput("rd_col", 32'(mem_rd_col), ec);
    endtask

    task automatic serve_read(input logic [2:0] pkt, input int lat, input int er, input int ec);
        wait_rd_en(er, ec);
        tick();
        repeat (lat) tick();
        mem_rd_valid = 1'b1;
        mem_rd_data  = pkt;
        tick();
        mem_rd_valid = 1'b0;
        mem_rd_data  = 3'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        checkOutput("idle_reached", 32'(busy), 0);
        tick();
    endtask

    // Monitor: counts done pulses and reads, and scores each output handshake
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) done_count++;
            if (mem_rd_en) rd_en_count++;
            if (out_valid && out_ready && !abort) begin
                checkOutput("beat_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    checkOutput("beat", 32'({query_out, database_out, out_last}), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        abort        = 1'b0;
        max_row      = '0;
        max_col      = '0;
        mem_rd_valid = 1'b0;
        mem_rd_data  = 3'b000;
        out_ready    = 1'b1;
        for (int i = 0; i < SL; i++) begin
            query_seq[i*LW +: LW]    = 2'($urandom);
            database_seq[i*LW +: LW] = 2'($urandom);
        end

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_done", 32'(done), 0);
        checkOutput("rst_err", 32'(err), 0);
        checkOutput("rst_out_valid", 32'(out_valid), 0);
        checkOutput("rst_out_last", 32'(out_last), 0);
        checkOutput("rst_align_len", 32'(align_len), 0);
        checkOutput("rst_rd_en", 32'(mem_rd_en), 0);
        checkOutput("rst_rd_row", 32'(mem_rd_row), 0);
        checkOutput("rst_rd_col", 32'(mem_rd_col), 0);
        checkOutput("rst_query_out", 32'(query_out), 0);
        checkOutput("rst_database_out", 32'(database_out), 0);
        rst_n = 1'b1;
        tick();

        // Diagonal walk
        $display("[TB] diagonal walk");
        done_base = done_count;
        exp_q.push_back({MARK, MARK, 1'b0});
        exp_q.push_back({q_sym(3), d_sym(3), 1'b0});
        exp_q.push_back({q_sym(2), d_sym(2), 1'b0});
        exp_q.push_back({MARK, MARK, 1'b1});
        applyStimulus(3, 3);
        serve_read(DIAG, 0, 3, 3);
        serve_read(DIAG, 2, 2, 2);
        serve_read(3'b100, 1, 1, 1);
        wait_idle();
        checkOutput("t1_done_count", done_count - done_base, 1);
        checkOutput("t1_done_low", 32'(done), 0);
        checkOutput("t1_align_len", 32'(align_len), 2);
        checkOutput("t1_err", 32'(err), 0);
        checkOutput("t1_sb_empty", exp_q.size(), 0);

        // Gaps, plus a start pulse while busy that must be ignored
        $display("[TB] gap handling");
        done_base = done_count;
        exp_q.push_back({MARK, MARK, 1'b0});
        exp_q.push_back({q_sym(2), GAP, 1'b0});
        exp_q.push_back({GAP, d_sym(2), 1'b0});
        exp_q.push_back({MARK, MARK, 1'b1});
        applyStimulus(2, 2);
        serve_read(LEFT, 0, 2, 2);
        max_row = 9;
        max_col = 9;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        serve_read(TOP, 1, 2, 1);
        serve_read(3'b000, 0, 1, 1);
        wait_idle();
        checkOutput("t2_done_count", done_count - done_base, 1);
        checkOutput("t2_align_len", 32'(align_len), 2);
        checkOutput("t2_err", 32'(err), 0);
        checkOutput("t2_end_row", 32'(mem_rd_row), 1);
        checkOutput("t2_end_col", 32'(mem_rd_col), 1);
        checkOutput("t2_sb_empty", exp_q.size(), 0);

        // Backpressure during EMIT, with a stray read response that must be ignored
        $display("[TB] backpressure");
        done_base = done_count;
        exp_q.push_back({MARK, MARK, 1'b0});
        exp_q.push_back({q_sym(4), d_sym(4), 1'b0});
        exp_q.push_back({MARK, MARK, 1'b1});
        applyStimulus(4, 4);
        tick();
        out_ready = 1'b0;
        serve_read(DIAG, 0, 4, 4);
        rd_base = rd_en_count;
        for (int i = 0; i < 5; i++) begin
            checkOutput("t3_valid", 32'(out_valid), 1);
            checkOutput("t3_query", 32'(query_out), 32'(q_sym(4)));
            checkOutput("t3_database", 32'(database_out), 32'(d_sym(4)));
            mem_rd_valid = (i == 2);
            mem_rd_data  = LEFT;
            tick();
        end
        mem_rd_valid = 1'b0;
        checkOutput("t3_no_extra_rd", rd_en_count - rd_base, 0);
        out_ready = 1'b1;
        serve_read(3'b100, 0, 3, 3);
        wait_idle();
        checkOutput("t3_done_count", done_count - done_base, 1);
        checkOutput("t3_align_len", 32'(align_len), 1);
        checkOutput("t3_sb_empty", exp_q.size(), 0);

        // Coordinate underflow on the first step
        $display("[TB] underflow");
        done_base = done_count;
        exp_q.push_back({MARK, MARK, 1'b0});
        exp_q.push_back({q_sym(4), d_sym(0), 1'b0});
        exp_q.push_back({MARK, MARK, 1'b1});
        applyStimulus(0, 4);
        rd_base = rd_en_count;
        serve_read(DIAG, 0, 0, 4);
        wait_idle();
        checkOutput("t4_done_count", done_count - done_base, 1);
        checkOutput("t4_err", 32'(err), 1);
        checkOutput("t4_reads", rd_en_count - rd_base, 1);
        checkOutput("t4_align_len", 32'(align_len), 1);
        checkOutput("t4_sb_empty", exp_q.size(), 0);

        // Abort while waiting for read data
        $display("[TB] abort");
        done_base = done_count;
        exp_q.push_back({MARK, MARK, 1'b0});
        applyStimulus(5, 5);
        wait_rd_en(5, 5);
        tick();
        abort        = 1'b1;
        mem_rd_valid = 1'b1;
        mem_rd_data  = DIAG;
        tick();
        abort = 1'b0;
        checkOutput("t5_idle", 32'(busy), 0);
        checkOutput("t5_no_valid", 32'(out_valid), 0);
        tick();
        mem_rd_valid = 1'b0;
        checkOutput("t5_still_idle", 32'(busy), 0);
        checkOutput("t5_still_no_valid", 32'(out_valid), 0);
        tick();
        checkOutput("t5_no_done", done_count - done_base, 0);
        checkOutput("t5_sb_empty", exp_q.size(), 0);

        // A normal traceback after the abort clears the sticky error
        done_base = done_count;
        exp_q.push_back({MARK, MARK, 1'b0});
        exp_q.push_back({GAP, d_sym(1), 1'b0});
        exp_q.push_back({MARK, MARK, 1'b1});
        applyStimulus(1, 1);
        checkOutput("t5_err_cleared", 32'(err), 0);
        serve_read(TOP, 0, 1, 1);
        serve_read(3'b111, 0, 0, 1);
        wait_idle();
        checkOutput("t5_done_count", done_count - done_base, 1);
        checkOutput("t5_err", 32'(err), 0);
        checkOutput("t5_align_len", 32'(align_len), 1);
        checkOutput("t5_sb_empty2", exp_q.size(), 0);

        // Reset asserted while a beat is stalled in EMIT
        $display("[TB] reset mid-emit");
        done_base = done_count;
        exp_q.push_back({MARK, MARK, 1'b0});
        applyStimulus(2, 3);
        tick();
        out_ready = 1'b0;
        serve_read(DIAG, 0, 2, 3);
        checkOutput("t6_in_emit", 32'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("t6_out_valid", 32'(out_valid), 0);
        checkOutput("t6_busy", 32'(busy), 0);
        checkOutput("t6_query", 32'(query_out), 0);
        checkOutput("t6_database", 32'(database_out), 0);
        checkOutput("t6_rd_en", 32'(mem_rd_en), 0);
        checkOutput("t6_align_len", 32'(align_len), 0);
        checkOutput("t6_out_last", 32'(out_last), 0);
        checkOutput("t6_done", 32'(done), 0);
        checkOutput("t6_err", 32'(err), 0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
        checkOutput("t6_idle_after", 32'(busy), 0);
        checkOutput("t6_no_valid_after", 32'(out_valid), 0);
        tick();
        checkOutput("t6_no_done", done_count - done_base, 0);
        checkOutput("t6_sb_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
